mem_dma: RTL and testbench

MEM_DMA -- requirements
Module: mem_dma

---
 rtl/mem_dma_pkg.sv | 28 ++
 rtl/mem_dma.sv | 199 +++++++++++++++++++
 tb/tb_mem_dma.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_pkg.sv
// Shared defines for the memory DMA block: bus width, state encoding and
// the word stride used by the address datapath.
`ifndef MEM_DMA_DEFINES
`define MEM_DMA_DEFINES
`define WIDTH 32
`endif

package mem_dma_pkg;

   // Transfer sequencer states.
   typedef enum logic [2:0] {
      IDLE,
      REQ,
      RD,
      CAP,
      WR,
      FIN
   } state_t;

   // Bytes advanced per transferred word.
   localparam int unsigned WORD_BYTES = 4;

   // Clear the byte-offset bits so every access is word aligned.
   function automatic logic [`WIDTH-1:0] word_align(input logic [`WIDTH-1:0] addr);
      return {addr[`WIDTH-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_dma.sv
// Memory DMA engine: copies or fills a run of 32-bit words through a
// single granted memory port. Copy = RD, CAP, WR per word; fill = one WR
// per word. Fill mode exists only when MEM_DMA_FILL_EN is defined;
// otherwise every transfer is a copy and mode_i/fill_i are ignored.
`ifndef WIDTH
`define WIDTH 32
`endif

module mem_dma
   import mem_dma_pkg::*;
#(
   parameter int LEN_W     = 16,
   parameter int GNT_PAUSE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              mode_i,
   input  logic [`WIDTH-1:0] src_i,
   input  logic [`WIDTH-1:0] dst_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic [`WIDTH-1:0] fill_i,
   input  logic              abort_i,
   output logic              bus_req_o,
   input  logic              bus_gnt_i,
   output logic              memread_o,
   output logic              memwrite_o,
   output logic [`WIDTH-1:0] memaddr_o,
   output logic [`WIDTH-1:0] memwdata_o,
   input  logic [`WIDTH-1:0] memrdata_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              aborted_o
);

   state_t             state;
   logic [`WIDTH-1:0]  src_q;
   logic [`WIDTH-1:0]  dst_q;
   logic [`WIDTH-1:0]  data_q;
   logic [`WIDTH-1:0]  fill_q;
   logic [LEN_W-1:0]   count_q;
   logic               fill_mode_q;
   logic               abort_pend;

   logic               req_fill;
   logic [`WIDTH-1:0]  req_pattern;
   logic [`WIDTH-1:0]  src_next;
   logic [`WIDTH-1:0]  dst_next;
   logic               abort_seen;
   logic               last_word;
   logic               gnt_lost;

`ifdef MEM_DMA_FILL_EN
   assign req_fill    = mode_i;
   assign req_pattern = fill_i;
`else
   // Copy-only build: the fill inputs have no function.
   logic unused_fill_inputs;
   assign unused_fill_inputs = ^{mode_i, fill_i};
   assign req_fill    = 1'b0;
   assign req_pattern = '0;
`endif

   // Next word addresses wrap modulo 2^WIDTH; abort is sticky until the word ends.
   always_comb begin
      src_next   = src_q + `WIDTH'(WORD_BYTES);
      dst_next   = dst_q + `WIDTH'(WORD_BYTES);
      abort_seen = abort_pend | abort_i;
      last_word  = (count_q == LEN_W'(1));
      gnt_lost   = (GNT_PAUSE != 0) && !bus_gnt_i;
   end

   // Sequencer, address/count datapath and registered outputs in one process.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: latched operands and counters are cleared too, so a reset
         // mid-transfer leaves no stale address or count behind.
         state       <= IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         data_q      <= '0;
         fill_q      <= '0;
         count_q     <= '0;
         fill_mode_q <= 1'b0;
         abort_pend  <= 1'b0;
         bus_req_o   <= 1'b0;
         memread_o   <= 1'b0;
         memwrite_o  <= 1'b0;
         memaddr_o   <= '0;
         memwdata_o  <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         aborted_o   <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; these defaults are overridden
         // below only in the cycle that enters a strobing or FIN state.
         memread_o  <= 1'b0;
         memwrite_o <= 1'b0;
         memaddr_o  <= '0;
         memwdata_o <= '0;
         done_o     <= 1'b0;
         aborted_o  <= 1'b0;

         case (state)
            IDLE: begin
               if (start_i) begin
                  src_q       <= word_align(src_i);
                  dst_q       <= word_align(dst_i);
                  count_q     <= len_i;
                  fill_mode_q <= req_fill;
                  fill_q      <= req_pattern;
                  abort_pend  <= 1'b0;
                  busy_o      <= 1'b1;
                  if (len_i == '0) begin
                     state  <= FIN;
                     done_o <= 1'b1;
                  end else begin
                     state     <= REQ;
                     bus_req_o <= 1'b1;
                  end
               end
            end

            REQ: begin
               if (abort_i) begin
                  state     <= FIN;
                  bus_req_o <= 1'b0;
                  done_o    <= 1'b1;
                  aborted_o <= 1'b1;
               end else if (bus_gnt_i) begin
                  if (fill_mode_q) begin
                     state      <= WR;
                     memwrite_o <= 1'b1;
                     memaddr_o  <= dst_q;
                     memwdata_o <= fill_q;
                  end else begin
                     state     <= RD;
                     memread_o <= 1'b1;
                     memaddr_o <= src_q;
                  end
               end
            end

            RD: begin
               abort_pend <= abort_seen;
               state      <= CAP;
            end

            CAP: begin
               abort_pend <= abort_seen;
               data_q     <= memrdata_i;
               state      <= WR;
               memwrite_o <= 1'b1;
               memaddr_o  <= dst_q;
               memwdata_o <= memrdata_i;
            end

            WR: begin
               count_q <= count_q - LEN_W'(1);
               dst_q   <= dst_next;
               if (!fill_mode_q) src_q <= src_next;
               if (last_word || abort_seen) begin
                  // Aborted only when words were actually left undone.
                  state      <= FIN;
                  bus_req_o  <= 1'b0;
                  done_o     <= 1'b1;
                  aborted_o  <= !last_word;
                  abort_pend <= 1'b0;
               end else if (gnt_lost) begin
                  state <= REQ;
               end else if (fill_mode_q) begin
                  state      <= WR;
                  memwrite_o <= 1'b1;
                  memaddr_o  <= dst_next;
                  memwdata_o <= fill_q;
               end else begin
                  state     <= RD;
                  memread_o <= 1'b1;
                  memaddr_o <= src_next;
               end
            end

            FIN: begin
               state      <= IDLE;
               busy_o     <= 1'b0;
               bus_req_o  <= 1'b0;
               abort_pend <= 1'b0;
            end

            default: begin
               state     <= IDLE;
               busy_o    <= 1'b0;
               bus_req_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: a transaction-level model predicts the
// ordered read/write strobes of each transfer; a per-cycle monitor checks
// them plus status/idle-bus rules, and directed tests pin timing literals.
module tb_mem_dma;

   localparam int LEN_W = 16;
`ifdef MEM_DMA_FILL_EN
   localparam bit FILL_EN = 1'b1;
`else
   localparam bit FILL_EN = 1'b0;
`endif

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } ev_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start_i = 1'b0;
   logic              mode_i = 1'b0;
   logic [31:0]       src_i = '0;
   logic [31:0]       dst_i = '0;
   logic [LEN_W-1:0]  len_i = '0;
   logic [31:0]       fill_i = '0;
   logic              abort_i = 1'b0;
   logic              bus_req_o;
   logic              bus_gnt_i = 1'b1;
   logic              memread_o;
   logic              memwrite_o;
   logic [31:0]       memaddr_o;
   logic [31:0]       memwdata_o;
   logic [31:0]       memrdata_i = 32'hDEAD_BEEF;
   logic              busy_o;
   logic              done_o;
   logic              aborted_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   ev_t         exp_q[$];
   ev_t         ev;
   logic [31:0] rd_log[$];
   logic [31:0] wr_log[$];
   int          wr_cyc[$];
   int          done_seen, done_cyc, grant_cyc, req_cycles, strobes, start_cyc;
   bit          grant_seen, exp_aborted, prev_done;
   logic        rd_pend = 1'b0;
   logic [31:0] rd_addr = '0;

   mem_dma #(.LEN_W(LEN_W), .GNT_PAUSE(1)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
      .src_i(src_i), .dst_i(dst_i), .len_i(len_i), .fill_i(fill_i),
      .abort_i(abort_i), .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
      .memread_o(memread_o), .memwrite_o(memwrite_o), .memaddr_o(memaddr_o),
      .memwdata_o(memwdata_o), .memrdata_i(memrdata_i), .busy_o(busy_o),
      .done_o(done_o), .aborted_o(aborted_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents as a fixed function of the word address.
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   // Memory answers one cycle after a read strobe; other cycles carry junk.
   always @(negedge clk) begin
      rd_pend <= memread_o;
      rd_addr <= memaddr_o;
   end
   always @(posedge clk) begin
      #1;
      memrdata_i = rd_pend ? mem_val(rd_addr) : 32'hDEAD_BEEF;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: ordered strobes a transfer of `words` words must produce.
   function automatic void expect_xfer(input bit mode, input logic [31:0] src,
                                       input logic [31:0] dst, input int words,
                                       input logic [31:0] pat);
      logic [31:0] s;
      logic [31:0] d;
      s = src & ~32'h3;
      d = dst & ~32'h3;
      for (int i = 0; i < words; i++) begin
         if (mode && FILL_EN) begin
            exp_q.push_back('{1'b1, d, pat});
         end else begin
            exp_q.push_back('{1'b0, s, 32'h0});
            exp_q.push_back('{1'b1, d, mem_val(s)});
         end
         s = s + 32'd4;
         d = d + 32'd4;
      end
   endfunction

   // Per-cycle monitor against the model and the bus/status rules.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         check("strobe_exclusive", memread_o & memwrite_o, 0);
         if (!memread_o && !memwrite_o) begin
            check("idle_addr", memaddr_o, 0);
            check("idle_wdata", memwdata_o, 0);
         end
         if (memread_o) begin
            strobes++;
            check("read_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               ev = exp_q.pop_front();
               check("read_kind", ev.wr, 0);
               check("read_addr", memaddr_o, ev.addr);
            end
            rd_log.push_back(memaddr_o);
         end
         if (memwrite_o) begin
            strobes++;
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               ev = exp_q.pop_front();
               check("write_kind", ev.wr, 1);
               check("write_addr", memaddr_o, ev.addr);
               check("write_data", memwdata_o, ev.data);
            end
            wr_log.push_back(memaddr_o);
            wr_cyc.push_back(cyc);
         end
         if (memread_o || memwrite_o) check("strobe_has_req", bus_req_o, 1);
         if (bus_req_o) begin
            req_cycles++;
            check("req_implies_busy", busy_o, 1);
            if (bus_gnt_i && !grant_seen) begin
               grant_seen = 1'b1;
               grant_cyc  = cyc;
            end
         end
         if (done_o) begin
            done_seen++;
            done_cyc = cyc;
            check("done_aborted", aborted_o, exp_aborted);
            check("done_pending_events", exp_q.size(), 0);
            check("done_no_req", bus_req_o, 0);
            check("done_busy", busy_o, 1);
         end
         if (prev_done) begin
            check("done_pulse_width", done_o, 0);
            check("idle_after_done", busy_o, 0);
         end
         prev_done = done_o;
      end else begin
         prev_done = 1'b0;
      end
   end

   task automatic start_xfer(input bit mode, input logic [31:0] src, input logic [31:0] dst,
                             input logic [LEN_W-1:0] len, input logic [31:0] pat);
      grant_seen = 1'b0;
      done_seen  = 0;
      req_cycles = 0;
      strobes    = 0;
      rd_log.delete();
      wr_log.delete();
      wr_cyc.delete();
      @(posedge clk); #1;
      mode_i = mode; src_i = src; dst_i = dst; len_i = len; fill_i = pat;
      start_i = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start_i = 1'b0;
      // Scramble the operands to show they were latched.
      mode_i = ~mode; src_i = 32'hFFFF_FFF0; dst_i = 32'hEEEE_EEE0; len_i = '1; fill_i = '1;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (done_seen == 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check(name, done_seen != 0, 1);
      @(posedge clk); #1;
   endtask

   // Wait (sampling after the negedge) until n reads or writes have been seen.
   task automatic wait_count(input bit wr, input int n, input int budget);
      int k;
      k = 0;
      do begin
         @(negedge clk); #1;
         k++;
      end while ((wr ? wr_log.size() : rd_log.size()) < n && k < budget);
      check("wait_count_timeout", (wr ? wr_log.size() : rd_log.size()) >= n, 1);
   endtask

   initial begin
      int s0;
      // Reset state.
      #3 rst = 1'b0;
      @(negedge clk);
      check("reset_ctrl", {bus_req_o, memread_o, memwrite_o, busy_o, done_o, aborted_o}, 0);
      check("reset_bus", memaddr_o | memwdata_o, 0);
      @(posedge clk); #1 rst = 1'b1;

      // Copy of 3 words, grant held; a second start while busy is ignored.
      exp_aborted = 1'b0;
      expect_xfer(1'b0, 32'h1000, 32'h1100, 3, 32'h0);
      start_xfer(1'b0, 32'h1000, 32'h1100, 3, 32'h0);
      repeat (4) @(posedge clk);
      #1; start_i = 1'b1; src_i = 32'h9000; len_i = 1;
      @(posedge clk); #1 start_i = 1'b0;
      wait_done("copy3_timeout", 60);
      check("copy3_done_cycle", done_cyc - grant_cyc, 10);
      check("copy3_writes", wr_log.size(), 3);
      check("copy3_rd0", rd_log[0], 32'h1000);
      check("copy3_rd2", rd_log[2], 32'h1008);
      check("copy3_wr1", wr_log[1], 32'h1104);
      repeat (3) @(posedge clk);
      #1;
      check("busy_start_ignored_done", done_seen, 1);
      check("busy_start_ignored_idle", busy_o, 0);

      // Fill of 4 words at the top of the address space.
      expect_xfer(1'b1, 32'h2000, 32'hFFF0_0000, 4, 32'h0000_0F0F);
      start_xfer(1'b1, 32'h2000, 32'hFFF0_0000, 4, 32'h0000_0F0F);
      wait_done("fill4_timeout", 60);
      check("fill4_last_addr", wr_log[3], 32'hFFF0_000C);
`ifdef MEM_DMA_FILL_EN
      check("fill4_no_reads", rd_log.size(), 0);
      check("fill4_back_to_back", wr_cyc[3] - wr_cyc[0], 3);
      check("fill4_done_after_last", done_cyc - wr_cyc[3], 1);
`else
      check("fill4_as_copy_reads", rd_log.size(), 4);
      check("fill4_as_copy_rd3", rd_log[3], 32'h200C);
`endif

      // Zero-length start finishes at once with no bus activity.
      start_xfer(1'b0, 32'h1000, 32'h1100, 0, 32'h0);
      wait_done("len0_timeout", 10);
      check("len0_done_cycle", done_cyc - start_cyc, 1);
      check("len0_strobes", strobes, 0);
      check("len0_bus_req", req_cycles, 0);

      // Copy of 5 with abort pulsed during the second word's CAP.
      exp_aborted = 1'b1;
      expect_xfer(1'b0, 32'h4000, 32'h4800, 2, 32'h0);
      start_xfer(1'b0, 32'h4000, 32'h4800, 5, 32'h0);
      wait_count(1'b0, 2, 40);
      @(posedge clk); #1 abort_i = 1'b1;
      @(posedge clk); #1 abort_i = 1'b0;
      wait_done("abort_timeout", 40);
      check("abort_writes", wr_log.size(), 2);
      check("abort_wr1", wr_log[1], 32'h4804);
      exp_aborted = 1'b0;

      // Grant withdrawn for 3 cycles after word 1 of a 3-word fill.
      expect_xfer(1'b1, 32'h6800, 32'h7000, 3, 32'hCAFE_0001);
      start_xfer(1'b1, 32'h6800, 32'h7000, 3, 32'hCAFE_0001);
      wait_count(1'b1, 1, 40);
      bus_gnt_i = 1'b0;
      s0 = strobes;
      repeat (3) @(negedge clk);
      #1;
      check("gap_no_strobes", strobes, s0);
      check("gap_req_held", bus_req_o, 1);
      bus_gnt_i = 1'b1;
      wait_done("gap_timeout", 40);
      check("gap_writes", wr_log.size(), 3);
      check("gap_wr1", wr_log[1], 32'h7004);
      check("gap_wr2", wr_log[2], 32'h7008);

      // Reset during the first WR of a copy: outputs clear, no done follows.
      expect_xfer(1'b0, 32'hFFFF_FFFC, 32'h3000, 2, 32'h0);
      start_xfer(1'b0, 32'hFFFF_FFFC, 32'h3000, 2, 32'h0);
      wait_count(1'b1, 1, 40);
      rst = 1'b0;
      #1;
      check("midreset_ctrl", {bus_req_o, memread_o, memwrite_o, busy_o, done_o, aborted_o}, 0);
      check("midreset_bus", memaddr_o | memwdata_o, 0);
      exp_q.delete();
      @(posedge clk); #1 rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("midreset_no_done", done_seen, 0);
      check("midreset_idle", busy_o, 0);

      // Fresh run afterwards: second read address wraps to zero.
      expect_xfer(1'b0, 32'hFFFF_FFFC, 32'h3000, 2, 32'h0);
      start_xfer(1'b0, 32'hFFFF_FFFC, 32'h3000, 2, 32'h0);
      wait_done("wrap_timeout", 40);
      check("wrap_rd0", rd_log[0], 32'hFFFF_FFFC);
      check("wrap_rd1", rd_log[1], 32'h0000_0000);
      check("wrap_wr1", wr_log[1], 32'h3004);

      // Unaligned operands are forced to word alignment.
      expect_xfer(1'b0, 32'h5002, 32'h6003, 1, 32'h0);
      start_xfer(1'b0, 32'h5002, 32'h6003, 1, 32'h0);
      wait_done("align_timeout", 30);
      check("align_rd", rd_log[0], 32'h5000);
      check("align_wr", wr_log[0], 32'h6000);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
